// File: rtl/stage_if.sv
// stage_if: RV32I fetch stage, assembles 32-bit words from a byte-wide
// memory port; ports: clk/reset, stall/stall_if, br/br_addr, mem_*, pc_out/inst/inst_valid.
module stage_if (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  output logic        stall_if,
  input  logic        br,
  input  logic [31:0] br_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst,
  output logic        inst_valid
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] bytes_q, bytes_d;
  logic [31:0] word_q, word_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic        fetch, take, done, redirect, hold_o;
  logic [31:0] full;

  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign fetch    = (state_q == FETCH);
  assign take     = fetch && mem_ready;
  assign done     = take && (cnt_q == 2'd3);
  assign redirect = br && !stall[2];
  assign hold_o   = stall[1];
  assign full     = {mem_rdata, bytes_q};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    bytes_d  = bytes_q;
    word_d   = word_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    if (redirect) begin
      // Redirect wins over completion, HOLD and output hold.
      pc_d    = br_addr;
      cnt_d   = 2'd0;
      state_d = FETCH;
      bytes_d = '0;
      word_d  = '0;
      inst_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (!hold_o) begin
        inst_d  = '0;
        valid_d = 1'b0;
      end
      unique case (state_q)
        FETCH: begin
          if (done) begin
            cnt_d   = 2'd0;
            bytes_d = '0;
            if (!hold_o) begin
              inst_d   = full;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_q + 32'd4;
            end else begin
              word_d  = full;
              state_d = HOLD;
            end
          end else if (take) begin
            cnt_d = cnt_q + 2'd1;
            unique case (1'b1)
              (cnt_q == 2'd0): bytes_d[7:0]   = mem_rdata;
              (cnt_q == 2'd1): bytes_d[15:8]  = mem_rdata;
              default:         bytes_d[23:16] = mem_rdata;
            endcase
          end
        end
        HOLD: begin
          if (!hold_o) begin
            inst_d   = word_q;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            state_d  = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      cnt_q    <= '0;
      bytes_q  <= '0;
      word_q   <= '0;
      pc_out_q <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      bytes_q  <= bytes_d;
      word_q   <= word_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  assign mem_req    = reset && fetch;
  assign mem_addr   = reset ? (pc_q + {30'd0, cnt_q}) : '0;
  assign stall_if   = reset && fetch && !done;
  assign pc_out     = pc_out_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;

endmodule
